enemy_wave_scheduler: RTL and testbench

- Sequences the enemy formation for one wave: paces step ticks, moves the formation horizontally, descends at the rims, tracks kills and declares win or lose.
- Sits between the game top level (start/kill events from collision logic) and the renderer, which consumes posX/posY/alive_mask.
- Step pace speeds up as enemies die.

---
 rtl/enemy_wave_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_enemy_wave_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: paces one enemy wave. It steps the formation sideways,
// descends at the rims, tracks kills and reports win or lose to the renderer
// and game top level.
// Optional build macro ENEMY_PAUSE_EN adds a 'pause' input. While pause is
// high in RUN, the tick counter holds and no step fires. Kills still land.
module enemy_wave_scheduler #(
  parameter int unsigned NUM_ENEMY   = 8,
  parameter int unsigned INIT_X      = 216,
  parameter int unsigned INIT_Y      = 0,
  parameter int unsigned LEFT_LIMIT  = 36,
  parameter int unsigned RIGHT_LIMIT = 216,
  parameter int unsigned STEP_X      = 12,
  parameter int unsigned STEP_Y      = 12,
  parameter int unsigned LOSE_Y      = 72,
  parameter int unsigned BASE_PERIOD = 25000000,
  parameter int unsigned SPEEDUP     = 2000000,
  parameter int unsigned MIN_PERIOD  = 4000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 kill_valid,
  input  logic [3:0]           kill_idx,
`ifdef ENEMY_PAUSE_EN
  input  logic                 pause,
`endif
  output logic                 kill_ack,
  output logic [9:0]           posX,
  output logic [9:0]           posY,
  output logic                 direction,
  output logic                 step,
  output logic [NUM_ENEMY-1:0] alive_mask,
  output logic [2:0]           state,
  output logic                 win,
  output logic                 lose
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DESCEND = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     period;
  int unsigned          alive_cnt;
  int unsigned          dead_cnt;
  longint               period_raw;
  logic                 hold_c;
  logic                 due;
  logic                 left_ok, right_ok, move_ok;
  logic                 kill_ok;
  logic [NUM_ENEMY-1:0] alive_d, alive_nxt;
  logic [POS_W-1:0]     posy_step;
  logic [POS_W-1:0]     posx_d, posy_d;
  logic                 dir_d, step_d, ack_d, win_d, lose_d;

`ifdef ENEMY_PAUSE_EN
  assign hold_c = pause;
`else
  assign hold_c = 1'b0;
`endif

  assign state = state_q;

  // Step period shrinks with each dead enemy, clamped to the floor
  always_comb begin
    alive_cnt = 0;
    for (int i = 0; i < int'(NUM_ENEMY); i++) begin
      alive_cnt = alive_cnt + 32'(alive_mask[i]);
    end
    dead_cnt   = NUM_ENEMY - alive_cnt;
    period_raw = longint'(BASE_PERIOD) - longint'(dead_cnt) * longint'(SPEEDUP);
    if (period_raw < longint'(MIN_PERIOD)) begin
      period = MIN_PERIOD;
    end else begin
      period = 32'(period_raw);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: step timing, rim detection, kill acceptance
  always_comb begin
    state_d   = state_q;
    kill_ok   = 1'b0;
    alive_d   = alive_mask;
    due       = (state_q == S_RUN) && !hold_c && (cnt_q >= (period - 32'd1));
    left_ok   = (32'(posX) >= (LEFT_LIMIT + STEP_X));
    right_ok  = ((32'(posX) + STEP_X) <= RIGHT_LIMIT);
    move_ok   = direction ? right_ok : left_ok;
    posy_step = posY + POS_W'(STEP_Y);

    // The loop compare keeps out-of-range indices from ever matching
    if (kill_valid && ((state_q == S_RUN) || (state_q == S_DESCEND))) begin
      for (int i = 0; i < int'(NUM_ENEMY); i++) begin
        if ((kill_idx == 4'(i)) && alive_mask[i]) begin
          kill_ok    = 1'b1;
          alive_d[i] = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (due && !move_ok) state_d = S_DESCEND;
        if (alive_d == '0)   state_d = S_WIN;
      end
      S_DESCEND: begin
        state_d = (32'(posy_step) >= LOSE_Y) ? S_LOSE : S_RUN;
        // Clearing the formation outranks reaching the lose line
        if (alive_d == '0) state_d = S_WIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    posx_d    = posX;
    posy_d    = posY;
    dir_d     = direction;
    alive_nxt = alive_d;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    ack_d     = kill_ok;
    win_d     = (state_d == S_WIN);
    lose_d    = (state_d == S_LOSE);

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          posx_d    = POS_W'(INIT_X);
          posy_d    = POS_W'(INIT_Y);
          dir_d     = 1'b0;
          alive_nxt = {NUM_ENEMY{1'b1}};
        end
      end
      S_RUN: begin
        if (due) begin
          cnt_d = '0;
          if (move_ok) begin
            posx_d = direction ? (posX + POS_W'(STEP_X)) : (posX - POS_W'(STEP_X));
            step_d = 1'b1;
          end
        end else if (!hold_c) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DESCEND: begin
        posy_d = posy_step;
        dir_d  = ~direction;
        step_d = 1'b1;
      end
      default: ;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      posX       <= POS_W'(INIT_X);
      posY       <= POS_W'(INIT_Y);
      direction  <= 1'b0;
      alive_mask <= {NUM_ENEMY{1'b1}};
      cnt_q      <= '0;
      step       <= 1'b0;
      kill_ack   <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      posX       <= posx_d;
      posY       <= posy_d;
      direction  <= dir_d;
      alive_mask <= alive_nxt;
      cnt_q      <= cnt_d;
      step       <= step_d;
      kill_ack   <= ack_d;
      win        <= win_d;
      lose       <= lose_d;
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Directed bench for enemy_wave_scheduler with a small, fast configuration.
module tb_enemy_wave_scheduler;

  localparam int unsigned NE = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          kill_valid;
  logic [3:0]    kill_idx;
`ifdef ENEMY_PAUSE_EN
  logic          pause;
`endif
  logic          kill_ack;
  logic [9:0]    posX;
  logic [9:0]    posY;
  logic          direction;
  logic          step;
  logic [NE-1:0] alive_mask;
  logic [2:0]    state;
  logic          win;
  logic          lose;

  int tests  = 0;
  int failed = 0;
  int n;

  enemy_wave_scheduler #(
    .NUM_ENEMY(NE), .BASE_PERIOD(8), .SPEEDUP(2), .MIN_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .kill_valid(kill_valid), .kill_idx(kill_idx),
`ifdef ENEMY_PAUSE_EN
    .pause(pause),
`endif
    .kill_ack(kill_ack), .posX(posX), .posY(posY), .direction(direction),
    .step(step), .alive_mask(alive_mask), .state(state), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until the next step pulse; returns the number of clocks taken
  task automatic wait_step(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((step !== 1'b1) && (cnt < 200));
    check("step_seen", 32'(step), 32'd1);
  endtask

  task automatic kill(input logic [3:0] idx);
    kill_valid = 1'b1;
    kill_idx   = idx;
    tick();
    kill_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_posX"},  32'(posX),  32'd216);
    check({tag, "_posY"},  32'(posY),  32'd0);
    check({tag, "_dir"},   32'(direction), 32'd0);
    check({tag, "_alive"}, 32'(alive_mask), 32'hF);
    check({tag, "_step"},  32'(step),  32'd0);
    check({tag, "_ack"},   32'(kill_ack), 32'd0);
    check({tag, "_win"},   32'(win),   32'd0);
    check({tag, "_lose"},  32'(lose),  32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    kill_valid = 1'b0;
    kill_idx   = 4'd0;
`ifdef ENEMY_PAUSE_EN
    pause      = 1'b0;
`endif
    #2 reset = 1'b0;
    #10;
    check_reset_values("rst");
    @(negedge clk) reset = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    // Start and first two steps at the full-formation pace
    start = 1'b1; tick(); start = 1'b0;
    check("start_state", 32'(state), 32'd1);
    check("start_posX", 32'(posX), 32'd216);
    wait_step(n);
    check("step1_gap", 32'(n), 32'd8);
    check("step1_posX", 32'(posX), 32'd204);
    wait_step(n);
    check("step2_gap", 32'(n), 32'd8);
    check("step2_posX", 32'(posX), 32'd192);
    check("step2_posY", 32'(posY), 32'd0);

    // March to the left rim, then descend
    repeat (13) wait_step(n);
    check("rim_posX", 32'(posX), 32'd36);
    check("rim_dir", 32'(direction), 32'd0);
    wait_step(n);
    check("desc_gap", 32'(n), 32'd9);
    check("desc_posY", 32'(posY), 32'd12);
    check("desc_dir", 32'(direction), 32'd1);
    check("desc_posX", 32'(posX), 32'd36);
    check("desc_state", 32'(state), 32'd1);
    wait_step(n);
    check("right_gap", 32'(n), 32'd8);
    check("right_posX", 32'(posX), 32'd48);

    // Kill acceptance and rejection
    kill(4'd1);
    check("kill1_ack", 32'(kill_ack), 32'd1);
    check("kill1_alive", 32'(alive_mask), 32'b1101);
    kill(4'd1);
    check("kill_dead_ack", 32'(kill_ack), 32'd0);
    kill(4'd9);
    check("kill_oor_ack", 32'(kill_ack), 32'd0);
    check("kill_oor_alive", 32'(alive_mask), 32'b1101);
    wait_step(n);
    wait_step(n);
    check("period6", 32'(n), 32'd6);
    kill(4'd0);
    kill(4'd2);
    check("kill02_alive", 32'(alive_mask), 32'b1000);
    wait_step(n);
    wait_step(n);
    check("period_floor", 32'(n), 32'd3);

    // Last kill wins the wave
    kill(4'd3);
    check("win_ack", 32'(kill_ack), 32'd1);
    check("win_alive", 32'(alive_mask), 32'd0);
    check("win_state", 32'(state), 32'd3);
    check("win_flag", 32'(win), 32'd1);
    check("win_lose", 32'(lose), 32'd0);
    repeat (5) tick();
    check("win_hold_state", 32'(state), 32'd3);
    check("win_hold_step", 32'(step), 32'd0);

    // Restart from WIN; start in RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("rs_state", 32'(state), 32'd1);
    check("rs_posX", 32'(posX), 32'd216);
    check("rs_posY", 32'(posY), 32'd0);
    check("rs_alive", 32'(alive_mask), 32'hF);
    check("rs_win", 32'(win), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("run_start_ign", 32'(state), 32'd1);
    check("run_start_posX", 32'(posX), 32'd216);

    // Descend all the way to the lose line
    kill(4'd0); kill(4'd1); kill(4'd2);
    for (int k = 0; k < 4000; k++) begin
      if (lose === 1'b1) break;
      tick();
    end
    check("lose_flag", 32'(lose), 32'd1);
    check("lose_state", 32'(state), 32'd4);
    check("lose_posY", 32'(posY), 32'd72);
    check("lose_posX", 32'(posX), 32'd216);
    check("lose_dir", 32'(direction), 32'd0);
    check("lose_win", 32'(win), 32'd0);
    repeat (5) tick();
    check("lose_hold_posX", 32'(posX), 32'd216);
    check("lose_hold_posY", 32'(posY), 32'd72);
    check("lose_hold_state", 32'(state), 32'd4);
    kill(4'd3);
    check("lose_kill_ack", 32'(kill_ack), 32'd0);
    check("lose_kill_alive", 32'(alive_mask), 32'b1000);
    start = 1'b1; tick(); start = 1'b0;
    check("rl_state", 32'(state), 32'd1);
    check("rl_alive", 32'(alive_mask), 32'hF);
    check("rl_lose", 32'(lose), 32'd0);
    check("rl_posY", 32'(posY), 32'd0);

    // Last kill during the descend that would reach the lose line
    kill(4'd0); kill(4'd1); kill(4'd2);
    for (int k = 0; k < 4000; k++) begin
      if ((state === 3'd2) && (posY === 10'd60)) break;
      tick();
    end
    check("pri_desc", 32'(state), 32'd2);
    kill(4'd3);
    check("pri_state", 32'(state), 32'd3);
    check("pri_win", 32'(win), 32'd1);
    check("pri_lose", 32'(lose), 32'd0);

    // Asynchronous reset in the middle of a descend
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (state === 3'd2) break;
      tick();
    end
    check("mid_desc", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clk) reset = 1'b1;
    tick();
    check("arst_idle", 32'(state), 32'd0);

`ifdef ENEMY_PAUSE_EN
    // Pause holds the tick count; stepping resumes where it left off
    begin
      logic seen;
      seen = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      pause = 1'b1;
      repeat (20) begin
        tick();
        seen = seen | step;
      end
      check("pause_nostep", 32'(seen), 32'd0);
      check("pause_posX", 32'(posX), 32'd216);
      pause = 1'b0;
      wait_step(n);
      check("pause_resume", 32'(n), 32'd5);
      check("pause_posX2", 32'(posX), 32'd204);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
